bless_local_ni: RTL and testbench
=================================

BLESS_LOCAL_NI -- requirements
Module: bless_local_ni

Interface
REQ-001 Parameter DEPTH, default 4, gives the entry count of each of the two flit FIFOs; it SHALL be a power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 16, gives the number of consecutive blocked injection cycles before starvation is flagged.
REQ-003 clk  input  1  single rising-edge clock; all state SHALL be clocked on it.
REQ-004 reset  input  1  asynchronous, active-low reset; low asserts.
REQ-005 core_flit  input  `WIDTH_PORT  flit from the core to be injected.
REQ-006 core_valid  input  1  core_flit is valid this cycle.
REQ-007 core_ready  output  1  the injection FIFO can accept a flit.
REQ-008 inject_ok  input  1  the router has a free input slot this cycle, meaning at least one of its W/E/S/N inputs is invalid.
REQ-009 dinLocal  output  `WIDTH_PORT  registered flit driven to the router's local input.
REQ-010 doutLocal  input  `WIDTH_PORT  flit ejected by the router's local output.
REQ-011 eject_flit  output  `WIDTH_PORT  head of the ejection FIFO.
REQ-012 eject_valid  output  1  eject_flit is valid.
REQ-013 eject_ready  input  1  the core consumes eject_flit this cycle.
REQ-014 starve  output  1  injection has been blocked for at least STARVE_LIMIT cycles.
REQ-015 eject_overflow  output  1  sticky flag: an ejected flit was dropped.
REQ-016 drop_count  output  8  count of dropped ejected flits; saturates at 255.

Function
REQ-017 Flit valid bit SHALL be bit `FLIT_VALID (= `WIDTH_PORT-1); a flit with this bit 0 is empty.
REQ-018 Injection push SHALL occur when core_valid && core_ready; core_ready SHALL equal (inj_count != DEPTH), from registered count.
REQ-019 Injection pop SHALL occur when the FIFO is non-empty and inject_ok=1.
REQ-020 On the clock edge at which a pop occurs, dinLocal SHALL take the head flit with the valid bit forced to 1.
REQ-021 On every other clock edge, dinLocal SHALL take all-zero.
REQ-022 Minimum latency: a flit pushed at edge N SHALL appear on dinLocal after edge N+1, if inject_ok=1 in cycle N+1.
REQ-023 Push and pop in the same cycle SHALL both take effect, leaving count unchanged; this includes the cycle in which the FIFO is full and a pop frees a slot (push is still refused because core_ready is registered low).
REQ-024 Ordering SHALL be strict FIFO.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 Ejection push SHALL occur whenever doutLocal valid bit = 1; the flit SHALL be stored unmodified.
REQ-027 eject_valid SHALL equal (ej_count != 0); eject_flit SHALL be the head entry.
REQ-028 Ejection pop SHALL occur on eject_valid && eject_ready.
REQ-029 Ejection push when full with no simultaneous pop SHALL drop the incoming flit: set eject_overflow, increment drop_count (saturating). Stored data SHALL be unchanged.
REQ-030 Ejection push when full with a simultaneous pop SHALL store the flit; no drop occurs.
REQ-031 Starvation counter SHALL increment, saturating at STARVE_LIMIT, in each cycle the injection FIFO is non-empty and inject_ok=0.
REQ-032 The starvation counter SHALL clear on any pop or when the injection FIFO is empty.
REQ-033 starve SHALL be 1 exactly when the starvation counter = STARVE_LIMIT.
REQ-034 eject_overflow and drop_count SHALL clear only on reset.

Reset
REQ-035 reset low SHALL immediately force: dinLocal=0, both counts and pointers=0, core_ready=1, eject_valid=0, starve=0, eject_overflow=0, drop_count=0, starvation counter=0.
REQ-036 Reset asserted mid-operation SHALL discard all buffered flits; no partial flit SHALL appear on dinLocal after deassertion.
REQ-037 FIFO storage arrays need not be reset.

Structure
REQ-038 `WIDTH_PORT and `FLIT_VALID SHALL live in global.v; no module-local redefinition is permitted.
REQ-039 One sub-module, ni_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/head), SHALL be instantiated twice: injection and ejection.
REQ-040 All other logic, including the dinLocal register, drop logic and starvation counter, SHALL be in bless_local_ni.

Verification
REQ-041 Reset then push flit 0x..A5 with inject_ok=1 held -> dinLocal = A5 with valid bit set exactly one cycle after it is accepted, then 0.
REQ-042 inject_ok=0, push 4 flits -> core_ready=0 after the 4th; a 5th offered flit is not accepted; raise inject_ok -> 4 flits leave in order on consecutive cycles.
REQ-043 One flit queued, inject_ok=0 for 16 cycles -> starve=1 at the 16th; inject_ok=1 -> flit injected, starve=0 the next cycle.
REQ-044 eject_ready=0, 5 valid flits on doutLocal -> first 4 stored, eject_overflow=1, drop_count=1; then eject_ready=1 -> the 4 flits delivered in order.
REQ-045 Ejection FIFO full, eject_ready=1 while a new flit arrives -> no drop, count stays 4.
REQ-046 reset pulsed low mid-burst between clock edges -> outputs reach reset values without a clock edge; no stale flit appears after release.

Source files
------------

// File: rtl/bless_local_ni_pkg.sv
// Shared flit parameters and helpers for the BLESS local network interface.
`include "global.v"

package bless_local_ni_pkg;

  localparam int FLIT_W   = `WIDTH_PORT;
  localparam int FLIT_VLD = `FLIT_VALID;

  function automatic logic [FLIT_W-1:0] set_valid(input logic [FLIT_W-1:0] f);
    logic [FLIT_W-1:0] r;
    r           = f;
    r[FLIT_VLD] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/global.v
// Global flit geometry shared by every NoC block.
`ifndef GLOBAL_V
`define GLOBAL_V
`define WIDTH_PORT 32
`define FLIT_VALID (`WIDTH_PORT-1)
`endif

// File: rtl/ni_fifo.sv
// Small synchronous FIFO; head is combinational from the read pointer.
// No internal overflow guard: the caller must only push when a slot is free or a pop frees one.
module ni_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bless_local_ni.sv
// Local NI for a bufferless router: queues core flits for injection when a router slot frees,
// buffers ejected flits for the core; 1-cycle registered injection, ejection drops when full.
`include "global.v"

module bless_local_ni
  import bless_local_ni_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [`WIDTH_PORT-1:0] core_flit,
  input  logic                   core_valid,
  output logic                   core_ready,
  input  logic                   inject_ok,
  output logic [`WIDTH_PORT-1:0] dinLocal,
  input  logic [`WIDTH_PORT-1:0] doutLocal,
  output logic [`WIDTH_PORT-1:0] eject_flit,
  output logic                   eject_valid,
  input  logic                   eject_ready,
  output logic                   starve,
  output logic                   eject_overflow,
  output logic [7:0]             drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic              inj_push, inj_pop, inj_full, inj_empty;
  logic [CW-1:0]     inj_count;
  logic [FLIT_W-1:0] inj_head;
  logic              ej_in_vld, ej_push, ej_pop, ej_full, ej_empty, ej_drop;
  logic [CW-1:0]     ej_count;

  logic [FLIT_W-1:0] din_q, din_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;

  assign core_ready = (inj_count != CW'(DEPTH));
  assign inj_push   = core_valid && core_ready;
  assign inj_pop    = !inj_empty && inject_ok;

  ni_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_inj_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (inj_push),
    .pop_i   (inj_pop),
    .din_i   (core_flit),
    .full_o  (inj_full),
    .empty_o (inj_empty),
    .count_o (inj_count),
    .head_o  (inj_head)
  );

  // A full ejection FIFO still accepts a flit when the core drains the head in the same cycle.
  assign ej_in_vld   = doutLocal[FLIT_VLD];
  assign eject_valid = (ej_count != '0);
  assign ej_pop      = eject_valid && eject_ready;
  assign ej_push     = ej_in_vld && (!ej_full || ej_pop);
  assign ej_drop     = ej_in_vld && ej_full && !ej_pop;

  ni_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_ej_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (ej_push),
    .pop_i   (ej_pop),
    .din_i   (doutLocal),
    .full_o  (ej_full),
    .empty_o (ej_empty),
    .count_o (ej_count),
    .head_o  (eject_flit)
  );

  logic unused_fifo_status;
  assign unused_fifo_status = inj_full ^ ej_empty;

  always_comb begin
    din_d        = '0;
    starve_cnt_d = starve_cnt_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    if (inj_pop) din_d = set_valid(inj_head);
    if (inj_pop || inj_empty) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    if (ej_drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_q        <= '0;
      starve_cnt_q <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      din_q        <= din_d;
      starve_cnt_q <= starve_cnt_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  assign dinLocal       = din_q;
  assign starve         = (starve_cnt_q == SW'(STARVE_LIMIT));
  assign eject_overflow = ovf_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_bless_local_ni.sv
// Directed bench for bless_local_ni: vector table for inject/eject flows, hand sequences for
// starvation, mid-cycle reset and drop-count saturation.
module tb_bless_local_ni;
  import bless_local_ni_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] core_flit;
  logic              core_valid;
  logic              core_ready;
  logic              inject_ok;
  logic [FLIT_W-1:0] dinLocal;
  logic [FLIT_W-1:0] doutLocal;
  logic [FLIT_W-1:0] eject_flit;
  logic              eject_valid;
  logic              eject_ready;
  logic              starve;
  logic              eject_overflow;
  logic [7:0]        drop_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bless_local_ni dut (
    .clk            (clk),
    .reset          (reset),
    .core_flit      (core_flit),
    .core_valid     (core_valid),
    .core_ready     (core_ready),
    .inject_ok      (inject_ok),
    .dinLocal       (dinLocal),
    .doutLocal      (doutLocal),
    .eject_flit     (eject_flit),
    .eject_valid    (eject_valid),
    .eject_ready    (eject_ready),
    .starve         (starve),
    .eject_overflow (eject_overflow),
    .drop_count     (drop_count)
  );

  typedef struct {
    logic [31:0] fl;
    logic        cv;
    logic        iok;
    logic [31:0] dl;
    logic        er;
    logic        rdy;
    logic [31:0] din;
    logic        ev;
    logic [31:0] ef;
    logic        stv;
    logic        ovf;
    logic [7:0]  dc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] fl, input logic cv, input logic iok,
                     input logic [31:0] dl, input logic er, input logic rdy,
                     input logic [31:0] din, input logic ev, input logic [31:0] ef,
                     input logic stv, input logic ovf, input logic [7:0] dc);
    vec_t v;
    v.fl = fl; v.cv = cv; v.iok = iok; v.dl = dl; v.er = er;
    v.rdy = rdy; v.din = din; v.ev = ev; v.ef = ef; v.stv = stv; v.ovf = ovf; v.dc = dc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".dinLocal"}, dinLocal, 32'h0);
    chk({tag, ".core_ready"}, {31'd0, core_ready}, 32'd1);
    chk({tag, ".eject_valid"}, {31'd0, eject_valid}, 32'd0);
    chk({tag, ".starve"}, {31'd0, starve}, 32'd0);
    chk({tag, ".eject_overflow"}, {31'd0, eject_overflow}, 32'd0);
    chk({tag, ".drop_count"}, {24'd0, drop_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; core_flit = '0; core_valid = 1'b0; inject_ok = 1'b0;
    doutLocal = '0; eject_ready = 1'b0;

    // fl, cv, iok, dl, er | rdy, din, ev, ef, stv, ovf, dc
    add(32'hA5, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0,      0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0,      0, 1, 0, 0,  1, 32'h800000A5, 0, 0, 0, 0, 0);
    add(0,      0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(1,      1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(2,      1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(3,      1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(4,      1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(5,      1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(5,      1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    add(0,      0, 1, 0, 0,  1, 32'h80000001, 0, 0, 0, 0, 0);
    add(0,      0, 1, 0, 0,  1, 32'h80000002, 0, 0, 0, 0, 0);
    add(0,      0, 1, 0, 0,  1, 32'h80000003, 0, 0, 0, 0, 0);
    add(0,      0, 0, 0, 0,  1, 32'h80000004, 0, 0, 0, 0, 0);
    add(0,      0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 32'h80000011, 0,  1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 32'h80000012, 0,  1, 0, 1, 32'h80000011, 0, 0, 0);
    add(0, 0, 0, 32'h80000013, 0,  1, 0, 1, 32'h80000011, 0, 0, 0);
    add(0, 0, 0, 32'h80000014, 0,  1, 0, 1, 32'h80000011, 0, 0, 0);
    add(0, 0, 0, 32'h80000015, 0,  1, 0, 1, 32'h80000011, 0, 0, 0);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000011, 0, 1, 1);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000012, 0, 1, 1);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000013, 0, 1, 1);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000014, 0, 1, 1);
    add(0, 0, 0, 0,            0,  1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 32'h80000021, 0,  1, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 32'h80000022, 0,  1, 0, 1, 32'h80000021, 0, 1, 1);
    add(0, 0, 0, 32'h80000023, 0,  1, 0, 1, 32'h80000021, 0, 1, 1);
    add(0, 0, 0, 32'h80000024, 0,  1, 0, 1, 32'h80000021, 0, 1, 1);
    add(0, 0, 0, 32'h80000025, 1,  1, 0, 1, 32'h80000021, 0, 1, 1);
    add(0, 0, 0, 32'h80000026, 0,  1, 0, 1, 32'h80000022, 0, 1, 1);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000022, 0, 1, 2);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000023, 0, 1, 2);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000024, 0, 1, 2);
    add(0, 0, 0, 0,            1,  1, 0, 1, 32'h80000025, 0, 1, 2);
    add(0, 0, 0, 0,            0,  1, 0, 0, 0, 0, 1, 2);

    // Reset state is visible before any clock edge.
    #3;
    chk_idle_outputs("reset0");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      core_flit = vecs[i].fl; core_valid = vecs[i].cv; inject_ok = vecs[i].iok;
      doutLocal = vecs[i].dl; eject_ready = vecs[i].er;
      #1;
      chk($sformatf("row%0d.core_ready", i), {31'd0, core_ready}, {31'd0, vecs[i].rdy});
      chk($sformatf("row%0d.dinLocal", i), dinLocal, vecs[i].din);
      chk($sformatf("row%0d.eject_valid", i), {31'd0, eject_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) chk($sformatf("row%0d.eject_flit", i), eject_flit, vecs[i].ef);
      chk($sformatf("row%0d.starve", i), {31'd0, starve}, {31'd0, vecs[i].stv});
      chk($sformatf("row%0d.eject_overflow", i), {31'd0, eject_overflow}, {31'd0, vecs[i].ovf});
      chk($sformatf("row%0d.drop_count", i), {24'd0, drop_count}, {24'd0, vecs[i].dc});
    end

    // Starvation: one queued flit blocked for STARVE_LIMIT cycles, counter saturates.
    @(negedge clk);
    core_flit = 32'h77; core_valid = 1'b1; inject_ok = 1'b0; doutLocal = '0; eject_ready = 1'b0;
    @(negedge clk);
    core_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("starve.k%0d", k), {31'd0, starve}, (k >= 16) ? 32'd1 : 32'd0);
    end
    inject_ok = 1'b1;
    @(negedge clk);
    #1;
    chk("starve.inject_din", dinLocal, 32'h80000077);
    chk("starve.cleared", {31'd0, starve}, 32'd0);

    // Mid-cycle reset during a burst on both sides.
    inject_ok = 1'b0; core_valid = 1'b1; core_flit = 32'h31; doutLocal = 32'h80000041;
    @(negedge clk);
    core_flit = 32'h32; doutLocal = 32'h80000042;
    @(negedge clk);
    core_flit = 32'h33; doutLocal = '0;
    @(negedge clk);
    core_valid = 1'b0; inject_ok = 1'b1;
    @(negedge clk);
    #1;
    chk("burst.din_before_reset", dinLocal, 32'h80000031);
    chk("burst.eject_valid_before_reset", {31'd0, eject_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_reset%0d.dinLocal", k), dinLocal, 32'h0);
      chk($sformatf("post_reset%0d.eject_valid", k), {31'd0, eject_valid}, 32'd0);
    end

    // Drop counter saturates at 255 with far more than 255 drops.
    inject_ok = 1'b0; eject_ready = 1'b0;
    for (int k = 0; k < 264; k++) begin
      @(negedge clk);
      doutLocal = 32'h80000050 + 32'(k);
    end
    @(negedge clk);
    doutLocal = '0;
    #1;
    chk("sat.drop_count", {24'd0, drop_count}, 32'd255);
    chk("sat.eject_overflow", {31'd0, eject_overflow}, 32'd1);
    chk("sat.eject_flit", eject_flit, 32'h80000050);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
